// File: rtl/board_io_pkg.sv
// Shared constants and types for the board input filter slice.
// Holds channel limit, default counter width, default prescale and the edge-enable pair.
package board_io_pkg;

   localparam int MAX_CH       = 32;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_PRESCALE = 1000;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_cfg_t;

endpackage : board_io_pkg

// File: rtl/board_debounce_ch.sv
// One filtered channel: flop synchronizer followed by a saturating debounce counter.
// rise_o/fall_o pulse combinationally in the cycle whose clock edge updates state_o.
module board_debounce_ch
   import board_io_pkg::*;
#(
   parameter int   CNT_W       = DEF_CNT_W,
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_BIT     = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_i,
   input  logic [CNT_W-1:0] limit_i,
   input  logic             tick_i,
   output logic             state_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   state_r;
   logic                   s_s;
   logic                   toggle_s;

   assign s_s      = sync_r[SYNC_STAGES-1];
   assign toggle_s = (s_s != state_r) && tick_i && (cnt_r >= limit_i);
   assign state_o  = state_r;
   assign rise_o   = toggle_s & s_s;
   assign fall_o   = toggle_s & ~s_s;

   // Input synchronizer chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{RST_BIT}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in_i};
      end
   end

   // Debounce counter and debounced level; >= compare means c can never pass L and wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= '0;
         state_r <= RST_BIT;
      end else if (s_s == state_r) begin
         cnt_r   <= '0;
      end else if (tick_i) begin
         if (cnt_r >= limit_i) begin
            state_r <= s_s;
            cnt_r   <= '0;
         end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r   <= cnt_r;
      end
   end

endmodule : board_debounce_ch

// File: rtl/board_input_filter.sv
// Debounced board inputs with sticky edge-pending flags and a masked interrupt.
// Define BOARD_INPUT_FILTER_PRESCALE_EN to slow the debounce count with a shared prescaler.
module board_input_filter
   import board_io_pkg::*;
#(
   parameter int              NUM_CH      = 8,
   parameter int              CNT_W       = DEF_CNT_W,
   parameter int              SYNC_STAGES = 2,
   parameter logic [NUM_CH-1:0] RST_VAL   = '0
`ifdef BOARD_INPUT_FILTER_PRESCALE_EN
   ,
   parameter int              PRESCALE    = DEF_PRESCALE
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] in_i,
   input  logic [CNT_W-1:0]  limit_i,
   input  logic [NUM_CH-1:0] rise_en_i,
   input  logic [NUM_CH-1:0] fall_en_i,
   input  logic [NUM_CH-1:0] clr_i,
   input  logic [NUM_CH-1:0] mask_i,
   output logic [NUM_CH-1:0] state_o,
   output logic [NUM_CH-1:0] pend_o,
   output logic              irq_o
);

   logic                    tick_s;
   logic [NUM_CH-1:0]       rise_s;
   logic [NUM_CH-1:0]       fall_s;
   logic [NUM_CH-1:0]       set_s;
   logic [NUM_CH-1:0]       pend_r;
   edge_cfg_t [NUM_CH-1:0]  edge_cfg_s;

`ifdef BOARD_INPUT_FILTER_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PS_W-1:0] ps_cnt_r;

   assign tick_s = (ps_cnt_r == PS_W'(PRESCALE - 1));

   // Free-running prescaler shared by every channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_cnt_r <= '0;
      end else if (tick_s) begin
         ps_cnt_r <= '0;
      end else begin
         ps_cnt_r <= ps_cnt_r + PS_W'(1);
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign edge_cfg_s[i].rise = rise_en_i[i];
      assign edge_cfg_s[i].fall = fall_en_i[i];
      assign set_s[i] = (rise_s[i] & edge_cfg_s[i].rise) | (fall_s[i] & edge_cfg_s[i].fall);

      board_debounce_ch #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .RST_BIT     (RST_VAL[i])
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .in_i    (in_i[i]),
         .limit_i (limit_i),
         .tick_i  (tick_s),
         .state_o (state_o[i]),
         .rise_o  (rise_s[i]),
         .fall_o  (fall_s[i])
      );
   end

   // Sticky pending flags; a new event outranks a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= '0;
      end else begin
         pend_r <= set_s | (pend_r & ~clr_i);
      end
   end

   assign pend_o = pend_r;
   assign irq_o  = |(pend_r & mask_i);

endmodule : board_input_filter

// File: tb/tb_board_input_filter.sv
// Scoreboard bench for board_input_filter (NUM_CH=4, two-stage sync, RST_VAL=0).
module tb_board_input_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_i, rise_en_i, fall_en_i, clr_i, mask_i;
   logic [15:0] limit_i;
   logic [3:0]  state_o, pend_o;
   logic        irq_o;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   localparam int K_STATE = 0, K_PEND = 1, K_IRQ = 2, K_STATEV = 3, K_PENDV = 4, K_CNT1 = 5;

   typedef struct {
      int    cyc;
      int    kind;
      int    idx;
      int    val;
      string name;
   } exp_t;

   exp_t exp_q[$];

   board_input_filter #(
      .NUM_CH      (4),
      .CNT_W       (16),
      .SYNC_STAGES (2),
      .RST_VAL     (4'b0000)
`ifdef BOARD_INPUT_FILTER_PRESCALE_EN
      ,
      .PRESCALE    (4)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_i      (in_i),
      .limit_i   (limit_i),
      .rise_en_i (rise_en_i),
      .fall_en_i (fall_en_i),
      .clr_i     (clr_i),
      .mask_i    (mask_i),
      .state_o   (state_o),
      .pend_o    (pend_o),
      .irq_o     (irq_o)
   );

   // expectation checked at the falling edge dly rising edges from now
   task automatic push_exp(input string name, input int kind, input int idx, input int val, input int dly);
      exp_t e;
      int   pos;
      e.cyc  = cyc + dly;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      e.name = name;
      pos = exp_q.size();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].cyc > e.cyc) begin
            pos = i;
            break;
         end
      end
      exp_q.insert(pos, e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int actual_of(input exp_t e);
      case (e.kind)
         K_STATE:  return int'(state_o[e.idx]);
         K_PEND:   return int'(pend_o[e.idx]);
         K_IRQ:    return int'(irq_o);
         K_STATEV: return int'(state_o);
         K_PENDV:  return int'(pend_o);
         K_CNT1:   return int'(dut.g_ch[1].u_ch.cnt_r);
         default:  return -1;
      endcase
   endfunction

   // monitor: pop every expectation due this cycle and compare
   always @(negedge clk) begin
      exp_t e;
      int   act;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e   = exp_q.pop_front();
         act = actual_of(e);
         n_vec++;
         if (e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s: check slot cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
         end else if (act != e.val) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, cyc);
         end
      end
   end

   initial begin
      rst = 1'b1; in_i = 4'b0000; limit_i = 16'd3;
      rise_en_i = 4'b1111; fall_en_i = 4'b1111; clr_i = 4'b0000; mask_i = 4'b0000;
      step(2);
      push_exp("rst_state", K_STATEV, 0, 0, 0);
      push_exp("rst_pend",  K_PENDV,  0, 0, 0);
      push_exp("rst_irq",   K_IRQ,    0, 0, 0);
      push_exp("rst_cnt1",  K_CNT1,   0, 0, 0);
      rst = 1'b0;
      step(2);

`ifdef BOARD_INPUT_FILTER_PRESCALE_EN
      limit_i = 16'd2;
      in_i[0] = 1'b1;
      push_exp("ps_state0_early", K_STATE, 0, 0, 10);
      push_exp("ps_state0_late",  K_STATE, 0, 1, 14);
      push_exp("ps_pend0",        K_PEND,  0, 1, 14);
      step(16);
`else
      // rise on ch0, L=3: 2 + 3 + 1 = 6 cycles
      in_i[0] = 1'b1;
      push_exp("lat_state0_pre", K_STATE, 0, 0, 5);
      push_exp("lat_state0",     K_STATE, 0, 1, 6);
      push_exp("lat_pend0_pre",  K_PEND,  0, 0, 5);
      push_exp("lat_pend0",      K_PEND,  0, 1, 6);
      step(8);
      clr_i = 4'b0001;
      push_exp("clr_pend0", K_PEND, 0, 0, 1);
      step(1);
      clr_i = 4'b0000;

      // 5-cycle glitch on ch1 with L=10
      limit_i = 16'd10;
      in_i[1] = 1'b1;
      push_exp("glitch_cnt_peak", K_CNT1,  1, 5, 7);
      push_exp("glitch_cnt_zero", K_CNT1,  1, 0, 8);
      push_exp("glitch_state1",   K_STATE, 1, 0, 7);
      push_exp("glitch_pend1",    K_PEND,  1, 0, 12);
      push_exp("glitch_state1_l", K_STATE, 1, 0, 20);
      step(5);
      in_i[1] = 1'b0;
      step(18);

      // set beats clear on ch2
      limit_i = 16'd3;
      in_i[2] = 1'b1;
      push_exp("ch2_rise_pend", K_PEND, 2, 1, 6);
      step(8);
      in_i[2] = 1'b0;
      step(5);
      clr_i = 4'b0100;
      push_exp("set_wins_pend2", K_PEND,  2, 1, 1);
      push_exp("set_wins_state", K_STATE, 2, 0, 1);
      step(1);
      clr_i = 4'b0000;
      step(2);
      clr_i = 4'b0100;
      push_exp("clr_pend2", K_PEND, 2, 0, 1);
      step(1);
      clr_i = 4'b0000;

      // mask gating of irq
      in_i[1] = 1'b1;
      step(8);
      mask_i = 4'b0001;
      push_exp("mask_pendv", K_PENDV, 0, 2, 0);
      push_exp("mask_irq0",  K_IRQ,   0, 0, 0);
      step(1);
      mask_i = 4'b0010;
      push_exp("mask_irq1",  K_IRQ,   0, 1, 0);
      step(1);
      mask_i = 4'b0000;

      // reset mid-debounce on ch1
      clr_i = 4'b0010;
      step(1);
      clr_i = 4'b0000;
      in_i[1] = 1'b0;
      step(8);
      clr_i = 4'b0010;
      step(1);
      clr_i = 4'b0000;
      push_exp("pre_rst_statev", K_STATEV, 0, 1, 0);
      limit_i = 16'd8;
      in_i[1] = 1'b1;
      push_exp("pre_rst_cnt4", K_CNT1, 1, 4, 6);
      step(7);
      rst = 1'b1;
      push_exp("rst_mid_cnt",    K_CNT1,   1, 0, 0);
      push_exp("rst_mid_statev", K_STATEV, 0, 0, 0);
      push_exp("rst_mid_pendv",  K_PENDV,  0, 0, 0);
      push_exp("rst_mid_irq",    K_IRQ,    0, 0, 0);
      in_i = 4'b0000;
      mask_i = 4'b1111;
      step(1);
      rst = 1'b0;
      push_exp("post_rst_pend_a",  K_PENDV,  0, 0, 3);
      push_exp("post_rst_pend_b",  K_PENDV,  0, 0, 10);
      push_exp("post_rst_statev",  K_STATEV, 0, 0, 10);
      push_exp("post_rst_irq",     K_IRQ,    0, 0, 10);
      step(12);
      mask_i = 4'b0000;

      // L=0: state follows s one cycle later
      limit_i = 16'd0;
      in_i[3] = 1'b1;
      push_exp("l0_state3_pre", K_STATE, 3, 0, 2);
      push_exp("l0_state3",     K_STATE, 3, 1, 3);
      step(5);

      // lowering L below the running count toggles on the next edge
      limit_i = 16'd10;
      in_i[2] = 1'b1;
      step(8);
      limit_i = 16'd3;
      push_exp("lower_l_pre",  K_STATE, 2, 0, 0);
      push_exp("lower_l_post", K_STATE, 2, 1, 1);
      step(3);
`endif

      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         step(1);
      end
      if (exp_q.size() != 0) begin
         n_err += exp_q.size();
         $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_board_input_filter

// File: doc/board_input_filter.md
BOARD_INPUT_FILTER -- requirements
Module: board_input_filter

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 8, giving the number of filtered input channels (1..32).
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the debounce counter width in bits.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (2..4).
REQ-004 The module SHALL have parameter RST_VAL, default '0, a NUM_CH-bit vector giving the per-channel reset level.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port in_i, input, NUM_CH bits: raw asynchronous board inputs (buttons, switches).
REQ-008 The module SHALL have port limit_i, input, CNT_W bits: debounce limit L, shared by all channels and quasi-static.
REQ-009 The module SHALL have port rise_en_i, input, NUM_CH bits: per-channel enable for rising-edge events.
REQ-010 The module SHALL have port fall_en_i, input, NUM_CH bits: per-channel enable for falling-edge events.
REQ-011 The module SHALL have port clr_i, input, NUM_CH bits: single-cycle write-1-to-clear strobe for the pending flags.
REQ-012 The module SHALL have port mask_i, input, NUM_CH bits: per-channel interrupt mask, where 1 = enabled.
REQ-013 The module SHALL have port state_o, output, NUM_CH bits: debounced level per channel.
REQ-014 The module SHALL have port pend_o, output, NUM_CH bits: sticky edge-event pending flags.
REQ-015 The module SHALL have port irq_o, output, 1 bit: the OR of pend_o & mask_i.

Function
REQ-016 Each channel SHALL pass in_i through a SYNC_STAGES-deep flop synchronizer; the synchronizer output is called s.
REQ-017 Each channel SHALL update its counter c and state every cycle as follows:
- if s == state: c <= 0
- else if c >= L: state <= s and c <= 0
- else: c <= c + 1
REQ-018 With s held stable and different from state, state_o SHALL toggle exactly L+1 cycles after s changes; total in_i-to-state_o latency is SYNC_STAGES+L+1 cycles.
REQ-019 A glitch on s shorter than L+1 cycles SHALL leave state_o unchanged and return c to 0.
REQ-020 L = 0 SHALL make state_o follow s with a 1-cycle delay.
REQ-021 If L is lowered below the current c, the ">=" compare SHALL cause a toggle on the next evaluation; c SHALL never wrap.
REQ-022 A 0->1 transition of state_o with rise_en_i set SHALL set pend_o in the same cycle state_o updates.
REQ-023 A 1->0 transition of state_o with fall_en_i set SHALL set pend_o in the same cycle state_o updates.
REQ-024 clr_i bit = 1 SHALL clear the corresponding pend_o bit on the next edge.
REQ-025 If set and clear occur in the same cycle, set SHALL win.
REQ-026 irq_o SHALL be combinational from the registered pend_o and mask_i; there SHALL be no extra latency.

Reset
REQ-027 While rst is asserted, the synchronizer flops and state_o SHALL equal RST_VAL; c, pend_o and irq_o SHALL be 0.
REQ-028 Reset assertion mid-debounce SHALL abort the count immediately.
REQ-029 After reset release, no pend_o bit SHALL set unless state_o actually leaves RST_VAL.

Configuration
REQ-030 Macro BOARD_INPUT_FILTER_PRESCALE_EN, when defined, SHALL add parameter PRESCALE (default 1000) and a shared free-running prescaler that emits a 1-cycle tick every PRESCALE clocks.
- Under this macro, the REQ-017 increment and toggle SHALL occur only on tick cycles; the clear-on-match SHALL still occur every cycle.
- Without the macro, every cycle SHALL be a tick (REQ-017 to REQ-021 exactly as written), and no prescaler logic SHALL exist.

Structure
REQ-031 Package board_io_pkg SHALL hold MAX_CH = 32, the default CNT_W, the default PRESCALE, and typedef edge_cfg_t (rise/fall enable pair).
REQ-032 The per-channel synchronizer, counter and state logic SHALL be sub-module board_debounce_ch, instantiated NUM_CH times via generate.
REQ-033 Pending, mask and irq logic, plus the optional prescaler, SHALL reside in board_input_filter.

Verification
REQ-034 The bench SHALL cover: NUM_CH=4, L=3, in_i[0] 0->1 held -> state_o[0] rises exactly 2+3+1=6 cycles later; pend_o[0]=1 if rise_en_i[0]=1.
REQ-035 The bench SHALL cover: L=10, in_i[1] pulse high for 5 cycles -> state_o[1] stays 0, pend_o[1] stays 0.
REQ-036 The bench SHALL cover: pend_o[2]=1 and a new fall event coincident with clr_i[2]=1 -> pend_o[2] stays 1; next clr_i[2] alone -> 0.
REQ-037 The bench SHALL cover: mask_i=4'b0001 with pend_o=4'b0010 -> irq_o=0; then mask_i=4'b0010 -> irq_o=1 in the same cycle.
REQ-038 The bench SHALL cover: rst asserted at c=5 with L=8 -> c=0 and state_o=RST_VAL immediately; after release with in_i=RST_VAL -> pend_o stays 0.
REQ-039 The bench SHALL cover: with BOARD_INPUT_FILTER_PRESCALE_EN and PRESCALE=4, L=2 -> state_o toggles after 3 ticks (9..12 cycles after s changes).
